axis_golden_checker: RTL and testbench
======================================

// Module: axis_golden_checker
// PURPOSE
//  Synthesizable AXI-Stream scoreboard for user-project FIR output. Passively taps a stream (tvalid/tready/tdata/tlast),
//  compares each beat with a loadable golden RAM, checks tlast position, counts errors/frames, and flags watchdog timeouts.
//  Sits beside fir_inst in user_proj_example; software loads golden data and reads results via wrapper registers.
// PARAMETERS
//  DATA_W      32      stream/golden data width
//  DEPTH       64      golden RAM depth = max frame length
//  ADDR_W      $clog2(DEPTH)  index width (derived)
//  TIMEOUT_CYC 250000  idle cycles in RUN (no beat) before timeout
// PORTS
//  wb_clk_i        in   1         clock
//  wb_rst_i        in   1         synchronous active-high reset
//  gold_we         in   1         golden RAM write strobe
//  gold_addr       in   ADDR_W    golden RAM write address
//  gold_wdata      in   DATA_W    golden RAM write data
//  cfg_len         in   ADDR_W+1  expected frame length, sampled at start
//  cont_en         in   1         1 = auto re-arm after each frame
//  start           in   1         arm checker (1-cycle pulse)
//  mon_tvalid      in   1         tapped tvalid
//  mon_tready      in   1         tapped tready
//  mon_tdata       in   DATA_W    tapped tdata
//  mon_tlast       in   1         tapped tlast
//  busy            out  1         state == RUN
//  done            out  1         1-cycle pulse at frame end
//  pass            out  1         last completed frame(s) error-free
//  err_cnt         out  16        saturating error count
//  first_err_idx   out  ADDR_W    beat index of first mismatch since start
//  first_err_data  out  DATA_W    received data at first mismatch
//  tlast_err       out  1         sticky: tlast early or missing
//  stray_beat      out  1         sticky: beat seen outside RUN
//  round_cnt       out  16        completed frames since start
//  timeout         out  1         watchdog expired
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; idx, watchdog 0. Golden RAM not reset.
//  Beat = mon_tvalid & mon_tready. Checker never drives the stream.
//  States: IDLE, RUN, DONE, TOUT. start in IDLE/DONE/TOUT -> RUN next edge;
//   clears idx, err_cnt, round_cnt, first_err_*, tlast_err, stray_beat, timeout, pass, watchdog; latches cfg_len
//   (0 or >DEPTH -> DEPTH). start while in RUN is ignored.
//  Compare: golden read asynchronously at idx; beat compared in its own cycle; counters update at that edge.
//   Mismatch: err_cnt+1; first mismatch latches first_err_idx/data.
//  tlast: expected exactly on idx==len-1. tlast with idx<len-1: tlast_err=1, err_cnt+1, frame ends.
//   idx==len-1 without tlast: tlast_err=1, err_cnt+1, frame ends. Data and tlast error on same beat: +2.
//  err_cnt saturates at 16'hFFFF; round_cnt wraps.
//  Frame end (edge after last beat): done=1 one cycle, round_cnt+1, pass=(err_cnt==0 incl. this beat).
//   cont_en=0 -> DONE; cont_en=1 -> stay RUN, idx=0, errors accumulate.
//  Watchdog: in RUN counts cycles without a beat, cleared on each beat; reaching TIMEOUT_CYC -> TOUT, timeout=1, busy=0.
//  Beat in IDLE/DONE/TOUT: stray_beat=1, no other effect.
//  gold_we honoured only when state!=RUN; dropped in RUN.
//  Reset mid-frame: all outputs return to reset values on the same edge; next start runs clean.
// TESTING
//  1 load 0..63 = i*3, cfg_len=64, start, 64 matching beats, tlast on 63 -> done pulse edge after beat 63, pass=1, err_cnt=0.
//  2 as 1, beat 5 data=0xDEAD, beat 17 wrong -> err_cnt=2, first_err_idx=5, first_err_data=0xDEAD, pass=0.
//  3 cfg_len=11, tlast on beat 9 -> tlast_err=1, err_cnt=1, done after beat 9, state DONE.
//  4 cont_en=1, cfg_len=11, three correct frames -> 3 done pulses, round_cnt=3, busy=1, pass=1.
//  5 TIMEOUT_CYC=100, start, no beats -> timeout=1 100 cycles after entering RUN; start clears it.
//  6 wb_rst_i at beat 20 of 64 -> all outputs 0 next edge; gold_we in RUN ignored; beat before start -> stray_beat=1.

Source files
------------

// File: rtl/axis_golden_checker.sv
// Passive AXI-Stream scoreboard: compares each tapped beat against a loadable golden RAM,
// checks the tlast position, counts errors and frames, and flags an idle watchdog timeout.
module axis_golden_checker #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              gold_we,
  input  logic [ADDR_W-1:0] gold_addr,
  input  logic [DATA_W-1:0] gold_wdata,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              cont_en,
  input  logic              start,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic [DATA_W-1:0] mon_tdata,
  input  logic              mon_tlast,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic              tlast_err,
  output logic              stray_beat,
  output logic [15:0]       round_cnt,
  output logic              timeout,
  output logic [1:0]        dbg_state
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [15:0]         round_q, round_d;
  logic [ADDR_W-1:0]   first_idx_q, first_idx_d;
  logic [DATA_W-1:0]   first_data_q, first_data_d;
  logic                have_first_q, have_first_d;
  logic                tlast_err_q, tlast_err_d;
  logic                stray_q, stray_d;
  logic                timeout_q, timeout_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   gold_mem_q [DEPTH];
  logic [DATA_W-1:0]   gold_rd;

  logic                beat, at_last, data_err, tl_err, frame_end;
  logic [1:0]          err_inc;
  logic [16:0]         err_sum;
  logic [15:0]         err_next;

  // Handshake: a beat is mon_tvalid & mon_tready in the same cycle; the checker only
  // observes both signals and never drives the stream.
  assign beat    = mon_tvalid & mon_tready;
  assign gold_rd = gold_mem_q[idx_q];

  always_comb begin
    at_last   = ({1'b0, idx_q} == (len_q - 1'b1));
    data_err  = (gold_rd != mon_tdata);
    tl_err    = mon_tlast ^ at_last;
    frame_end = mon_tlast | at_last;
    err_inc   = {1'b0, data_err} + {1'b0, tl_err};
    err_sum   = {1'b0, err_cnt_q} + {15'd0, err_inc};
    err_next  = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    wd_d         = wd_q;
    err_cnt_d    = err_cnt_q;
    round_d      = round_q;
    first_idx_d  = first_idx_q;
    first_data_d = first_data_q;
    have_first_d = have_first_q;
    tlast_err_d  = tlast_err_q;
    stray_d      = stray_q;
    timeout_d    = timeout_q;
    pass_d       = pass_q;
    done_d       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (beat) begin
          wd_d      = '0;
          err_cnt_d = err_next;
          if (data_err && !have_first_q) begin
            have_first_d = 1'b1;
            first_idx_d  = idx_q;
            first_data_d = mon_tdata;
          end
          if (tl_err) tlast_err_d = 1'b1;
          if (frame_end) begin
            idx_d   = '0;
            done_d  = 1'b1;
            round_d = round_q + 16'd1;
            pass_d  = (err_next == 16'd0);
            state_d = cont_en ? ST_RUN : ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (wd_q == WD_LAST) begin
          wd_d      = '0;
          timeout_d = 1'b1;
          state_d   = ST_TOUT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d      = ST_RUN;
          idx_d        = '0;
          wd_d         = '0;
          err_cnt_d    = '0;
          round_d      = '0;
          first_idx_d  = '0;
          first_data_d = '0;
          have_first_d = 1'b0;
          tlast_err_d  = 1'b0;
          stray_d      = 1'b0;
          timeout_d    = 1'b0;
          pass_d       = 1'b0;
          // A zero or oversized length means "use the whole golden RAM".
          len_d = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;
        end else if (beat) begin
          stray_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      wd_q         <= '0;
      err_cnt_q    <= '0;
      round_q      <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
      have_first_q <= 1'b0;
      tlast_err_q  <= 1'b0;
      stray_q      <= 1'b0;
      timeout_q    <= 1'b0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      wd_q         <= wd_d;
      err_cnt_q    <= err_cnt_d;
      round_q      <= round_d;
      first_idx_q  <= first_idx_d;
      first_data_q <= first_data_d;
      have_first_q <= have_first_d;
      tlast_err_q  <= tlast_err_d;
      stray_q      <= stray_d;
      timeout_q    <= timeout_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
    end
  end

  // Golden contents survive reset; writes during a run would corrupt the live compare.
  always_ff @(posedge wb_clk_i) begin
    if (gold_we && (state_q != ST_RUN)) gold_mem_q[gold_addr] <= gold_wdata;
  end

  assign busy           = (state_q == ST_RUN);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_idx  = first_idx_q;
  assign first_err_data = first_data_q;
  assign tlast_err      = tlast_err_q;
  assign stray_beat     = stray_q;
  assign round_cnt      = round_q;
  assign timeout        = timeout_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_axis_golden_checker.sv
// Scoreboard bench for axis_golden_checker: a small frame model pushes expected
// end-of-frame results, which are popped and compared whenever done pulses.
module tb_axis_golden_checker;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int EXP_W  = 72;

  logic              clk = 1'b0;
  logic              rst;
  logic              gold_we;
  logic [ADDR_W-1:0] gold_addr;
  logic [DATA_W-1:0] gold_wdata;
  logic [ADDR_W:0]   cfg_len;
  logic              cont_en, start;
  logic              tvalid, tready, tlast;
  logic [DATA_W-1:0] tdata;
  logic              busy, done, pass, tlast_err, stray_beat, timeout;
  logic [15:0]       err_cnt, round_cnt;
  logic [ADDR_W-1:0] first_err_idx;
  logic [DATA_W-1:0] first_err_data;
  logic [1:0]        dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [EXP_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] gold_m [DEPTH];

  int                m_idx, m_len;
  logic              m_run, m_cont, m_have_first, m_tlast_err;
  logic [15:0]       m_err, m_round;
  logic [ADDR_W-1:0] m_first_idx;
  logic [DATA_W-1:0] m_first_data;

  axis_golden_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYC(100)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .gold_we(gold_we), .gold_addr(gold_addr),
    .gold_wdata(gold_wdata), .cfg_len(cfg_len), .cont_en(cont_en), .start(start),
    .mon_tvalid(tvalid), .mon_tready(tready), .mon_tdata(tdata), .mon_tlast(tlast),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data),
    .tlast_err(tlast_err), .stray_beat(stray_beat), .round_cnt(round_cnt),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tvalid = 1'($urandom_range(0, 1));
      tready = tvalid ? 1'b0 : 1'($urandom_range(0, 1));
      tdata  = $urandom;
      tlast  = 1'($urandom_range(0, 1));
      tick();
    end
    tvalid = 1'b0;
    tready = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic load_gold();
    for (int i = 0; i < DEPTH; i++) begin
      gold_we    = 1'b1;
      gold_addr  = ADDR_W'(i);
      gold_wdata = DATA_W'(i * 3);
      gold_m[i]  = DATA_W'(i * 3);
      tick();
    end
    gold_we = 1'b0;
  endtask

  task automatic do_start(input int len, input logic cont);
    cfg_len = (ADDR_W + 1)'(len);
    cont_en = cont;
    start   = 1'b1;
    tick();
    start        = 1'b0;
    m_len        = (len == 0 || len > DEPTH) ? DEPTH : len;
    m_idx        = 0;
    m_run        = 1'b1;
    m_cont       = cont;
    m_err        = '0;
    m_round      = '0;
    m_have_first = 1'b0;
    m_tlast_err  = 1'b0;
    m_first_idx  = '0;
    m_first_data = '0;
  endtask

  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic l);
    logic is_last, ended;
    idle_cycles($urandom_range(0, 2));
    tvalid  = 1'b1;
    tready  = 1'b1;
    tdata   = d;
    tlast   = l;
    ended   = 1'b0;
    is_last = (m_idx == m_len - 1);
    if (d != gold_m[m_idx]) begin
      if (m_err != 16'hFFFF) m_err++;
      if (!m_have_first) begin
        m_have_first = 1'b1;
        m_first_idx  = ADDR_W'(m_idx);
        m_first_data = d;
      end
    end
    if (l != is_last) begin
      if (m_err != 16'hFFFF) m_err++;
      m_tlast_err = 1'b1;
    end
    if (l || is_last) begin
      m_round++;
      exp_q.push_back({m_err, m_round, m_first_idx, m_first_data, (m_err == 16'd0), m_tlast_err});
      m_idx = 0;
      m_run = m_cont;
      ended = 1'b1;
    end else begin
      m_idx++;
    end
    tick();
    tvalid = 1'b0;
    tready = 1'b0;
    tlast  = 1'b0;
    if (ended) check("done_timing", done, 1);
  endtask

  task automatic run_frame(input int n, input int last_at, input int b1, input logic [DATA_W-1:0] d1,
                           input int b2, input logic [DATA_W-1:0] d2);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = gold_m[i];
      if (i == b1) d = d1;
      if (i == b2) d = d2;
      drive_beat(d, i == last_at);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_state();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_idx", first_err_idx, 0);
    check("rst_first_data", first_err_data, 0);
    check("rst_tlast_err", tlast_err, 0);
    check("rst_stray", stray_beat, 0);
    check("rst_round", round_cnt, 0);
    check("rst_timeout", timeout, 0);
    check("rst_state", dbg_state, 0);
  endtask

  // Scoreboard: pop one expected result per done pulse
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_err_cnt", err_cnt, e[71:56]);
        check("sb_round", round_cnt, e[55:40]);
        check("sb_first_idx", first_err_idx, e[39:34]);
        check("sb_first_data", first_err_data, e[33:2]);
        check("sb_pass", pass, e[1]);
        check("sb_tlast_err", tlast_err, e[0]);
      end
    end
  end

  initial begin
    int cnt;
    rst = 1'b1; gold_we = 1'b0; gold_addr = '0; gold_wdata = '0; cfg_len = '0;
    cont_en = 1'b0; start = 1'b0; tvalid = 1'b0; tready = 1'b0; tdata = '0; tlast = 1'b0;
    m_run = 1'b0; m_cont = 1'b0; m_idx = 0; m_len = DEPTH;
    repeat (3) tick();
    check_reset_state();
    rst = 1'b0;
    tick();

    // Stray beat before any start
    tvalid = 1'b1; tready = 1'b1; tdata = 32'h55; tick();
    tvalid = 1'b0; tready = 1'b0;
    check("stray_idle", stray_beat, 1);
    check("stray_no_err", err_cnt, 0);

    load_gold();

    // Clean full-length frame
    do_start(64, 1'b0);
    check("start_clears_stray", stray_beat, 0);
    check("busy_run", busy, 1);
    run_frame(64, 63, -1, 0, -1, 0);
    drain();
    check("state_done", dbg_state, 2);

    // Two data mismatches
    do_start(64, 1'b0);
    run_frame(64, 63, 5, 32'hDEAD, 17, 32'h1234);
    drain();

    // Early tlast, missing tlast, data + tlast error on the same beat
    do_start(11, 1'b0);
    run_frame(10, 9, -1, 0, -1, 0);
    drain();
    check("early_state_done", dbg_state, 2);
    check("early_busy", busy, 0);
    do_start(5, 1'b0);
    run_frame(5, -1, -1, 0, -1, 0);
    drain();
    do_start(5, 1'b0);
    run_frame(3, 2, 2, 32'hBAD, -1, 0);
    drain();

    // Watchdog
    do_start(11, 1'b0);
    cnt = 0;
    while (!timeout && cnt < 300) begin
      tick();
      cnt++;
    end
    check("timeout_latency", cnt, 100);
    check("timeout_busy", busy, 0);
    check("timeout_state", dbg_state, 3);

    // Restart from timeout with len 0 (full RAM); golden write during run must be dropped
    do_start(0, 1'b0);
    check("start_clears_timeout", timeout, 0);
    gold_we = 1'b1; gold_addr = '0; gold_wdata = 32'hFFFF_FFFF; tick();
    gold_we = 1'b0;
    run_frame(64, 63, -1, 0, -1, 0);
    drain();

    // Reset mid-frame, then a clean run with an oversized length
    do_start(64, 1'b0);
    run_frame(20, -1, 5, 32'h77, -1, 0);
    rst = 1'b1;
    tick();
    check_reset_state();
    rst = 1'b0;
    m_run = 1'b0;
    check("q_empty_at_reset", exp_q.size(), 0);
    do_start(100, 1'b0);
    run_frame(64, 63, -1, 0, -1, 0);
    drain();

    // Continuous mode: three clean frames, then one with an error
    do_start(11, 1'b1);
    for (int f = 0; f < 3; f++) run_frame(11, 10, -1, 0, -1, 0);
    drain();
    check("cont_busy", busy, 1);
    check("cont_round", round_cnt, 3);
    check("cont_pass", pass, 1);
    check("cont_state", dbg_state, 1);
    run_frame(11, 10, 4, 32'h0, -1, 0);
    drain();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
